// File: rtl/cla_acc_pkg.sv
// Shared types and constants for the CLA-based sample accumulator.
package cla_acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } acc_state_t;

  localparam int CLA_WIDTH   = 6;
  localparam int COUNT_WIDTH = 8;

endpackage

// File: rtl/carry_lookahead_adder_6bit.sv
// Combinational 6-bit carry-lookahead adder; o_result[6] is the carry-out.
module carry_lookahead_adder_6bit (
  input  logic [5:0] i_add1,
  input  logic [5:0] i_add2,
  output logic [6:0] o_result
);

  logic [5:0] gen;
  logic [5:0] prop;
  logic [6:0] carry;

  assign gen  = i_add1 & i_add2;
  assign prop = i_add1 ^ i_add2;

  // Every carry is flattened from generate/propagate terms, so none waits on a lower carry.
  assign carry[0] = 1'b0;
  assign carry[1] = gen[0];
  assign carry[2] = gen[1] | (prop[1] & gen[0]);
  assign carry[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0]);
  assign carry[4] = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
                  | (prop[3] & prop[2] & prop[1] & gen[0]);
  assign carry[5] = gen[4] | (prop[4] & gen[3]) | (prop[4] & prop[3] & gen[2])
                  | (prop[4] & prop[3] & prop[2] & gen[1])
                  | (prop[4] & prop[3] & prop[2] & prop[1] & gen[0]);
  assign carry[6] = gen[5] | (prop[5] & gen[4]) | (prop[5] & prop[4] & gen[3])
                  | (prop[5] & prop[4] & prop[3] & gen[2])
                  | (prop[5] & prop[4] & prop[3] & prop[2] & gen[1])
                  | (prop[5] & prop[4] & prop[3] & prop[2] & prop[1] & gen[0]);

  assign o_result = {carry[6], prop ^ carry[5:0]};

endmodule

// File: rtl/cla_accumulator_6bit.sv
// Accumulates NUM_SAMPLES 6-bit samples: low slice through the CLA, upper bits as a carry-driven incrementer.
module cla_accumulator_6bit
  import cla_acc_pkg::*;
#(
  parameter int NUM_SAMPLES = 8,
  parameter int ACC_WIDTH   = 12
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic                   i_valid,
  input  logic [CLA_WIDTH-1:0]   i_data,
  output logic                   o_ready,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [ACC_WIDTH-1:0]   o_sum,
  output logic [COUNT_WIDTH-1:0] o_count,
  output logic                   o_overflow
);

  localparam int UPPER_WIDTH = ACC_WIDTH - CLA_WIDTH;

  acc_state_t state, next_state;

  logic [ACC_WIDTH-1:0]   acc;
  logic [COUNT_WIDTH-1:0] count;
  logic                   overflow;
  logic                   done_q;
  logic [CLA_WIDTH:0]     cla_result;
  logic [UPPER_WIDTH-1:0] upper;
  logic [UPPER_WIDTH-1:0] upper_next;
  logic                   accept;
  logic                   start_go;
  logic                   last_sample;

  carry_lookahead_adder_6bit u_cla (
    .i_add1   (acc[CLA_WIDTH-1:0]),
    .i_add2   (i_data),
    .o_result (cla_result)
  );

  assign upper       = acc[ACC_WIDTH-1:CLA_WIDTH];
  assign upper_next  = upper + UPPER_WIDTH'(cla_result[CLA_WIDTH]);
  assign accept      = (state == ACCUM) && i_valid;
  assign start_go    = i_start && (state != ACCUM);
  assign last_sample = (count == COUNT_WIDTH'(NUM_SAMPLES - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (i_start) next_state = ACCUM;
      ACCUM:   if (accept && last_sample) next_state = DONE;
      DONE:    if (i_start) next_state = ACCUM;
      default: next_state = IDLE;
    endcase
  end

  // A start from IDLE or DONE clears the run; start during ACCUM never reaches here.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc      <= '0;
      count    <= '0;
      overflow <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= accept && last_sample;
      if (start_go) begin
        acc      <= '0;
        count    <= '0;
        overflow <= 1'b0;
      end else if (accept) begin
        acc <= {upper_next, cla_result[CLA_WIDTH-1:0]};
        if (count != COUNT_WIDTH'(NUM_SAMPLES)) count <= count + 1'b1;
        if ((&upper) && cla_result[CLA_WIDTH]) overflow <= 1'b1;
      end
    end
  end

  always_comb begin
    o_ready = (state == ACCUM);
    o_busy  = (state == ACCUM);
    o_done  = done_q;
  end

  assign o_sum      = acc;
  assign o_count    = count;
  assign o_overflow = overflow;

endmodule

// File: tb/tb_cla_accumulator_6bit.sv
// Directed self-checking bench for cla_accumulator_6bit (default and 7-bit/4-sample instances).
module tb_cla_accumulator_6bit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, valid;
  logic [5:0]  data;
  logic        ready, busy, done, overflow;
  logic [11:0] sum;
  logic [7:0]  count;

  logic        start7, valid7;
  logic [5:0]  data7;
  logic        ready7, busy7, done7, overflow7;
  logic [6:0]  sum7;
  logic [7:0]  count7;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cla_accumulator_6bit dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_valid(valid), .i_data(data),
    .o_ready(ready), .o_busy(busy), .o_done(done), .o_sum(sum), .o_count(count),
    .o_overflow(overflow)
  );

  cla_accumulator_6bit #(.NUM_SAMPLES(4), .ACC_WIDTH(7)) dut7 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start7), .i_valid(valid7), .i_data(data7),
    .o_ready(ready7), .o_busy(busy7), .o_done(done7), .o_sum(sum7), .o_count(count7),
    .o_overflow(overflow7)
  );

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; valid = 1'b0; data = '0;
    start7 = 1'b0; valid7 = 1'b0; data7 = '0;

    // Reset with no start
    tick(3);
    rst_n = 1'b1;
    tick(2);
    check_output("rst_sum", 32'(sum), 0);
    check_output("rst_ready", 32'(ready), 0);
    check_output("rst_done", 32'(done), 0);
    check_output("rst_count", 32'(count), 0);
    check_output("rst_busy", 32'(busy), 0);
    check_output("idle_valid_ignored", 32'(count), 0);

    // 8 samples of 1 with valid held high; start during last acceptance ignored
    valid = 1'b1; data = 6'd1;
    tick();
    check_output("idle_valid_no_accept", 32'(sum), 0);
    pulse_start();
    check_output("t1_ready", 32'(ready), 1);
    check_output("t1_busy", 32'(busy), 1);
    tick(3);
    check_output("t1_count3", 32'(count), 3);
    check_output("t1_sum3", 32'(sum), 3);
    tick(4);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_output("t1_sum", 32'(sum), 8);
    check_output("t1_count", 32'(count), 8);
    check_output("t1_done", 32'(done), 1);
    check_output("t1_busy_done", 32'(busy), 0);
    check_output("t1_ready_done", 32'(ready), 0);
    check_output("t1_ovf", 32'(overflow), 0);
    tick();
    check_output("t1_done_pulse", 32'(done), 0);
    check_output("t1_sum_hold", 32'(sum), 8);
    check_output("t1_count_sat", 32'(count), 8);

    // 8 samples of 63 restarted from DONE
    data = 6'd63;
    pulse_start();
    check_output("t2_clear_sum", 32'(sum), 0);
    check_output("t2_clear_count", 32'(count), 0);
    tick(2);
    check_output("t2_sum2", 32'(sum), 126);
    tick(6);
    check_output("t2_sum", 32'(sum), 504);
    check_output("t2_done", 32'(done), 1);
    check_output("t2_ovf", 32'(overflow), 0);

    // One sample of 5, a 10-cycle stall, then 7 samples of 10
    valid = 1'b0;
    pulse_start();
    valid = 1'b1; data = 6'd5;
    tick();
    valid = 1'b0; data = 6'd33;
    tick(10);
    check_output("t3_stall_busy", 32'(busy), 1);
    check_output("t3_stall_count", 32'(count), 1);
    check_output("t3_stall_sum", 32'(sum), 5);
    valid = 1'b1; data = 6'd10;
    tick(6);
    check_output("t3_not_done", 32'(done), 0);
    tick();
    valid = 1'b0;
    check_output("t3_sum", 32'(sum), 75);
    check_output("t3_count", 32'(count), 8);
    check_output("t3_done", 32'(done), 1);

    // ACC_WIDTH=7, NUM_SAMPLES=4: upper field wraps on the third sample
    start7 = 1'b1;
    tick();
    start7 = 1'b0;
    valid7 = 1'b1; data7 = 6'd63;
    tick(2);
    check_output("w7_sum2", 32'(sum7), 126);
    check_output("w7_ovf2", 32'(overflow7), 0);
    tick();
    check_output("w7_sum3", 32'(sum7), 61);
    check_output("w7_ovf3", 32'(overflow7), 1);
    tick();
    valid7 = 1'b0;
    check_output("w7_sum", 32'(sum7), 124);
    check_output("w7_ovf", 32'(overflow7), 1);
    check_output("w7_done", 32'(done7), 1);
    check_output("w7_count", 32'(count7), 4);
    tick();
    check_output("w7_ovf_hold", 32'(overflow7), 1);
    start7 = 1'b1;
    tick();
    start7 = 1'b0;
    check_output("w7_ovf_clear", 32'(overflow7), 0);

    // Asynchronous reset mid-run, then a fresh run of 8x2
    pulse_start();
    valid = 1'b1; data = 6'd1;
    tick(3);
    check_output("r_pre_count", 32'(count), 3);
    #2 rst_n = 1'b0;
    #1;
    check_output("r_sum", 32'(sum), 0);
    check_output("r_count", 32'(count), 0);
    check_output("r_busy", 32'(busy), 0);
    check_output("r_ready", 32'(ready), 0);
    check_output("r_done", 32'(done), 0);
    check_output("r_ovf7", 32'(overflow7), 0);
    tick();
    rst_n = 1'b1;
    tick();
    check_output("r_idle_ready", 32'(ready), 0);
    check_output("r_idle_sum", 32'(sum), 0);
    data = 6'd2;
    pulse_start();
    tick(8);
    valid = 1'b0;
    check_output("r_sum16", 32'(sum), 16);
    check_output("r_done16", 32'(done), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
